// File: rtl/um_operand_fetch.sv
// Operand fetch sequencer: reads A/B/C from the register bank, emits an operand bundle, performs writebacks.
// Latency: bundle valid 1 + n*(1+READ_WAIT) cycles after the instr handshake; a writeback strobes the following cycle.
// Backpressure: bundle held in EMIT until op_ready; instr/wb only accepted in IDLE, wb taking priority.
package um_operand_fetch_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  sel;
        logic        mode;
    } reg_in_bus_t;
endpackage

module um_operand_fetch
    import um_operand_fetch_pkg::*;
#(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [3:0]  op_code,
    output logic [2:0]  op_a_sel,
    output logic [31:0] op_ra,
    output logic [31:0] op_rb,
    output logic [31:0] op_rc,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_sel,
    input  logic [31:0] wb_data,
    output reg_in_bus_t reg_out,
    input  logic [31:0] reg_q
);

    localparam int CW = (READ_WAIT < 1) ? 1 : $clog2(READ_WAIT + 1);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, EMIT, WR} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          rd_last;
    logic [2:0]    sel_b;
    logic [2:0]    sel_c;
    logic [1:0]    rd_bc;
    logic [2:0]    wr_sel;
    logic [31:0]   wr_data;
    logic          is_orth;

    // {A,B,C} read set of an opcode
    function automatic logic [2:0] read_set(input logic [3:0] op);
        case (op)
            4'd0, 4'd2:                                return 3'b111;
            4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd12:       return 3'b011;
            4'd8, 4'd9, 4'd10:                         return 3'b001;
            default:                                   return 3'b000;
        endcase
    endfunction

    function automatic state_t first_from(input logic [2:0] set);
        if (set[2])      return RD_A;
        else if (set[1]) return RD_B;
        else if (set[0]) return RD_C;
        else             return EMIT;
    endfunction

    assign rd_last = (cnt == CW'(READ_WAIT));
    assign is_orth = (instr[31:28] == 4'd13);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_code  <= '0;
            op_a_sel <= '0;
            sel_b    <= '0;
            sel_c    <= '0;
            rd_bc    <= '0;
            op_ra    <= '0;
            op_rb    <= '0;
            op_rc    <= '0;
            wr_sel   <= '0;
            wr_data  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == RD_A || state == RD_B || state == RD_C) && !rd_last)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            case (state)
                IDLE: begin
                    if (wb_valid) begin
                        wr_sel  <= wb_sel;
                        wr_data <= wb_data;
                    end else if (instr_valid) begin
                        if (is_orth) begin
                            wr_sel  <= instr[27:25];
                            wr_data <= {7'b0, instr[24:0]};
                        end else begin
                            op_code  <= instr[31:28];
                            op_a_sel <= instr[8:6];
                            sel_b    <= instr[5:3];
                            sel_c    <= instr[2:0];
                            rd_bc    <= read_set(instr[31:28]) & 3'b011;
                            op_ra    <= '0;
                            op_rb    <= '0;
                            op_rc    <= '0;
                        end
                    end
                end
                RD_A: if (rd_last) op_ra <= reg_q;
                RD_B: if (rd_last) op_rb <= reg_q;
                RD_C: if (rd_last) op_rc <= reg_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (wb_valid)
                    state_nxt = WR;
                else if (instr_valid)
                    state_nxt = is_orth ? WR : first_from(read_set(instr[31:28]));
            end
            RD_A:    if (rd_last) state_nxt = first_from({1'b0, rd_bc});
            RD_B:    if (rd_last) state_nxt = first_from({2'b0, rd_bc[0]});
            RD_C:    if (rd_last) state_nxt = EMIT;
            EMIT:    if (op_ready) state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reg_out     = '0;
        op_valid    = 1'b0;
        wb_ready    = 1'b0;
        instr_ready = 1'b0;
        unique case (state)
            IDLE: begin
                wb_ready    = 1'b1;
                instr_ready = !wb_valid;
            end
            RD_A: reg_out.sel = op_a_sel;
            RD_B: reg_out.sel = sel_b;
            RD_C: reg_out.sel = sel_c;
            EMIT: op_valid = 1'b1;
            WR: begin
                reg_out.data = wr_data;
                reg_out.sel  = wr_sel;
                reg_out.mode = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
